// File: rtl/dpram_asym_if.sv
// Write/read port bundle for dpram_asym: narrow write side, wide read side.
// The slave modport is the memory; the master modport is whoever drives it.
interface dpram_asym_if #(
  parameter int WR_W  = 8,
  parameter int RATIO = 4,
  parameter int DEPTH = 16,
  parameter int RD_W  = WR_W * RATIO,
  parameter int RA_W  = $clog2(DEPTH),
  parameter int WA_W  = RA_W + $clog2(RATIO)
);
  logic            wr_en_i;
  logic [WA_W-1:0] wr_addr_i;
  logic [WR_W-1:0] wr_data_i;
  logic            rd_en_i;
  logic [RA_W-1:0] rd_addr_i;
  logic [RD_W-1:0] rd_data_o;
  logic            rd_valid_o;
  logic            collision_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i,
    input  rd_data_o, rd_valid_o, collision_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i,
    output rd_data_o, rd_valid_o, collision_o
  );
endinterface

// File: rtl/dpram_asym.sv
// Asymmetric simple dual-port RAM: narrow lane writes, wide registered reads,
// read-first on same-word collisions, with a zero-fill sweep after every reset.
module dpram_asym #(
  parameter int DLY    = 1,
  parameter int WR_W   = 8,
  parameter int RATIO  = 4,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 1,
  parameter int RD_W   = WR_W * RATIO,
  parameter int RA_W   = $clog2(DEPTH),
  parameter int WA_W   = RA_W + $clog2(RATIO)
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  output logic         init_done_o,
  dpram_asym_if.slave  bus
);
  localparam int LW = $clog2(RATIO);

  typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [RA_W-1:0] cnt_q, cnt_d;
  logic            init_done_q, init_done_d;

  logic [RD_W-1:0] mem [DEPTH];

  logic [RA_W-1:0]  wr_word;
  logic [RATIO-1:0] wr_lane_oh;
  logic             wr_fire, rd_fire;
  logic [RA_W-1:0]  mem_waddr;
  logic [RATIO-1:0] mem_lane_we;
  logic [RD_W-1:0]  mem_wdata;
  logic [RD_W-1:0]  rd_raw_q;
  logic             v1_q, v1_d;
  logic             c1_q, c1_d;

  // DLY only shaped simulation timing in the original netlist style.
  logic unused_dly;
  assign unused_dly = (DLY != 0);

  generate
    if (RATIO == 1) begin : g_single_lane
      assign wr_word    = bus.wr_addr_i;
      assign wr_lane_oh = 1'b1;
    end else begin : g_multi_lane
      assign wr_word    = bus.wr_addr_i[WA_W-1:LW];
      assign wr_lane_oh = RATIO'(1) << bus.wr_addr_i[LW-1:0];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == RA_W'(DEPTH - 1)) state_d = READY;
    end
    // Registered from the next state so it rises on the same edge as READY.
    init_done_d = (state_d == READY);
  end

  always_comb begin
    wr_fire = (state_q == READY) && bus.wr_en_i;
    rd_fire = (state_q == READY) && bus.rd_en_i;
    if (state_q == INIT) begin
      mem_waddr   = cnt_q;
      mem_lane_we = '1;
      mem_wdata   = '0;
    end else begin
      mem_waddr   = wr_word;
      mem_lane_we = wr_fire ? wr_lane_oh : '0;
      mem_wdata   = {RATIO{bus.wr_data_i}};
    end
    v1_d = rd_fire;
    c1_d = rd_fire && wr_fire && (wr_word == bus.rd_addr_i);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      v1_q        <= 1'b0;
      c1_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      v1_q        <= v1_d;
      c1_q        <= c1_d;
    end
  end

  // No reset on the array; nonblocking read gives read-first behaviour.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < RATIO; l++) begin
      if (mem_lane_we[l]) mem[mem_waddr][l*WR_W +: WR_W] <= mem_wdata[l*WR_W +: WR_W];
    end
    if (rd_fire) rd_raw_q <= mem[bus.rd_addr_i];
  end

  assign init_done_o = init_done_q;

  generate
    if (RD_LAT == 1) begin : g_lat1
      logic have_data_q, have_data_d;
      assign have_data_d = have_data_q | v1_q;
      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) have_data_q <= 1'b0;
        else         have_data_q <= have_data_d;
      end
      // Mask stale read-register contents until a post-reset read lands.
      assign bus.rd_data_o   = (v1_q || have_data_q) ? rd_raw_q : '0;
      assign bus.rd_valid_o  = v1_q;
      assign bus.collision_o = c1_q;
    end else begin : g_lat2
      logic            v2_q, c2_q;
      logic [RD_W-1:0] d2_q, d2_d;
      assign d2_d = v1_q ? rd_raw_q : d2_q;
      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          v2_q <= 1'b0;
          c2_q <= 1'b0;
          d2_q <= '0;
        end else begin
          v2_q <= v1_q;
          c2_q <= c1_q;
          d2_q <= d2_d;
        end
      end
      assign bus.rd_data_o   = d2_q;
      assign bus.rd_valid_o  = v2_q;
      assign bus.collision_o = c2_q;
    end
  endgenerate
endmodule

// File: tb/tb_dpram_asym.sv
// Randomized bench for dpram_asym: byte-array reference model plus a queue of
// expected read returns; a second instance covers RATIO=1 with RD_LAT=1.
module tb_dpram_asym;
  localparam int DEPTH  = 16;
  localparam int RATIO  = 4;
  localparam int RD_LAT = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  logic done_a, done_b;
  always #5 clk = ~clk;

  dpram_asym_if #(.WR_W(8), .RATIO(4), .DEPTH(16)) bus_a ();
  dpram_asym_if #(.WR_W(8), .RATIO(1), .DEPTH(16)) bus_b ();

  dpram_asym #(.WR_W(8), .RATIO(4), .DEPTH(16), .RD_LAT(2)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .init_done_o(done_a), .bus(bus_a));
  dpram_asym #(.WR_W(8), .RATIO(1), .DEPTH(16), .RD_LAT(1)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .init_done_o(done_b), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  typedef struct { int due; logic [31:0] data; logic coll; } exp_t;
  exp_t        pend[$];
  logic [7:0]  mdl [64];
  int          edges = 0;
  int          since = 0;
  bit          in_reset = 1'b0;
  logic [31:0] last_data = '0;
  logic [31:0] e_data;
  logic        e_valid, e_coll, e_done;

  function automatic logic [31:0] word_of(int w);
    return {mdl[4*w+3], mdl[4*w+2], mdl[4*w+1], mdl[4*w]};
  endfunction

  // One clock of instance A; the model predicts what should be visible after the edge.
  task automatic tick_a(input bit we, input int wa, input logic [7:0] wd, input bit re, input int ra);
    exp_t e;
    bus_a.wr_en_i = we; bus_a.wr_addr_i = 6'(wa); bus_a.wr_data_i = wd;
    bus_a.rd_en_i = re; bus_a.rd_addr_i = 4'(ra);
    @(posedge clk);
    if (!in_reset) begin
      if (since >= DEPTH) begin
        if (re) begin
          e.due = edges + RD_LAT - 1;
          e.data = word_of(ra);
          e.coll = we && (wa / RATIO == ra);
          pend.push_back(e);
        end
        if (we) mdl[wa] = wd;
      end
      since++;
    end
    #1;
    e_valid = 1'b0; e_coll = 1'b0; e_data = last_data;
    if (pend.size() > 0 && pend[0].due == edges) begin
      e_valid = 1'b1; e_coll = pend[0].coll; e_data = pend[0].data;
      last_data = e_data;
      pend.delete(0);
    end
    e_done = !in_reset && since >= DEPTH;
    edges++;
  endtask

  task automatic enter_reset();
    rstn = 1'b0; in_reset = 1'b1; pend.delete(); last_data = '0; since = 0;
    for (int i = 0; i < 64; i++) mdl[i] = 8'h00;
  endtask

  task automatic leave_reset();
    rstn = 1'b1; in_reset = 1'b0;
  endtask

  task automatic test_reset();
    enter_reset();
    for (int i = 0; i < 4; i++) begin
      tick_a(1'b1, int'($urandom_range(63)), 8'($urandom), 1'b1, int'($urandom_range(15)));
      checks += 4;
      if (bus_a.rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus_a.rd_valid_o); end
      if (bus_a.collision_o !== 1'b0) begin errors++; $display("FAIL reset_coll: got %b want 0", bus_a.collision_o); end
      if (bus_a.rd_data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 00000000", bus_a.rd_data_o); end
      if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_a); end
    end
    leave_reset();
  endtask

  task automatic test_init();
    int rise_at = -1;
    for (int i = 0; i < DEPTH; i++) begin
      tick_a(1'b1, int'($urandom_range(63)), 8'($urandom | 1), 1'b1, int'($urandom_range(15)));
      if (done_a === 1'b1 && rise_at < 0) rise_at = i + 1;
      checks += 2;
      if (done_a !== e_done) begin errors++; $display("FAIL init_done cyc %0d: got %b want %b", i + 1, done_a, e_done); end
      if (bus_a.rd_valid_o !== 1'b0) begin errors++; $display("FAIL init_valid cyc %0d: got %b want 0", i + 1, bus_a.rd_valid_o); end
    end
    checks++;
    if (rise_at != DEPTH) begin errors++; $display("FAIL init_rise: got cycle %0d want %0d", rise_at, DEPTH); end
    for (int i = 0; i < DEPTH + 1; i++) begin
      tick_a(1'b0, 0, 8'h00, i < DEPTH, i);
      checks += 2;
      if (bus_a.rd_valid_o !== e_valid) begin errors++; $display("FAIL clear_valid %0d: got %b want %b", i, bus_a.rd_valid_o, e_valid); end
      if (e_valid && bus_a.rd_data_o !== 32'h0) begin errors++; $display("FAIL clear_data %0d: got %h want 00000000", i, bus_a.rd_data_o); end
    end
  endtask

  task automatic test_lanes();
    int pulses = 0;
    for (int i = 0; i < 4; i++) tick_a(1'b1, 'h14 + i, 8'(8'h11 * (i + 1)), 1'b0, 0);
    tick_a(1'b0, 0, 8'h00, 1'b1, 5);
    for (int i = 0; i < 3; i++) begin
      tick_a(1'b0, 0, 8'h00, 1'b0, 0);
      if (bus_a.rd_valid_o === 1'b1) begin
        pulses++;
        checks++;
        if (bus_a.rd_data_o !== 32'h44332211) begin errors++; $display("FAIL lanes_data: got %h want 44332211", bus_a.rd_data_o); end
      end
      checks++;
      if (bus_a.rd_valid_o !== e_valid) begin errors++; $display("FAIL lanes_valid %0d: got %b want %b", i, bus_a.rd_valid_o, e_valid); end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL lanes_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_collision();
    tick_a(1'b1, 'h0C, 8'hDD, 1'b0, 0);
    tick_a(1'b1, 'h0D, 8'hCC, 1'b0, 0);
    tick_a(1'b1, 'h0E, 8'hBB, 1'b0, 0);
    tick_a(1'b1, 'h0F, 8'hAA, 1'b0, 0);
    tick_a(1'b1, 'h0D, 8'hEE, 1'b1, 3);
    tick_a(1'b0, 0, 8'h00, 1'b0, 0);
    checks += 3;
    if (bus_a.rd_valid_o !== 1'b1) begin errors++; $display("FAIL coll_valid: got %b want 1", bus_a.rd_valid_o); end
    if (bus_a.rd_data_o !== 32'hAABBCCDD) begin errors++; $display("FAIL coll_data: got %h want aabbccdd", bus_a.rd_data_o); end
    if (bus_a.collision_o !== 1'b1) begin errors++; $display("FAIL coll_flag: got %b want 1", bus_a.collision_o); end
    tick_a(1'b0, 0, 8'h00, 1'b1, 3);
    checks++;
    if (bus_a.collision_o !== 1'b0) begin errors++; $display("FAIL coll_clear: got %b want 0", bus_a.collision_o); end
    tick_a(1'b0, 0, 8'h00, 1'b0, 0);
    checks += 2;
    if (bus_a.rd_data_o !== 32'hAABBEEDD) begin errors++; $display("FAIL coll_after: got %h want aabbeedd", bus_a.rd_data_o); end
    if (bus_a.collision_o !== 1'b0) begin errors++; $display("FAIL coll_after_flag: got %b want 0", bus_a.collision_o); end
  endtask

  task automatic test_back_to_back();
    int run = 0;
    for (int i = 0; i < 24; i++) tick_a(1'b1, int'($urandom_range(63)), 8'($urandom), 1'b0, 0);
    for (int i = 0; i < DEPTH + RD_LAT - 1; i++) begin
      tick_a(1'b0, 0, 8'h00, i < DEPTH, i);
      if (bus_a.rd_valid_o === 1'b1) run++;
      checks += 3;
      if (bus_a.rd_valid_o !== e_valid) begin errors++; $display("FAIL b2b_valid %0d: got %b want %b", i, bus_a.rd_valid_o, e_valid); end
      if (bus_a.rd_data_o !== e_data) begin errors++; $display("FAIL b2b_data %0d: got %h want %h", i, bus_a.rd_data_o, e_data); end
      if (bus_a.collision_o !== 1'b0) begin errors++; $display("FAIL b2b_coll %0d: got %b want 0", i, bus_a.collision_o); end
    end
    checks++;
    if (run != DEPTH) begin errors++; $display("FAIL b2b_count: got %0d want %0d", run, DEPTH); end
    for (int i = 0; i < 3; i++) begin
      tick_a(1'b0, 0, 8'h00, 1'b0, 0);
      checks += 2;
      if (bus_a.rd_valid_o !== 1'b0) begin errors++; $display("FAIL hold_valid %0d: got %b want 0", i, bus_a.rd_valid_o); end
      if (bus_a.rd_data_o !== word_of(15)) begin errors++; $display("FAIL hold_data %0d: got %h want %h", i, bus_a.rd_data_o, word_of(15)); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int  wa = int'($urandom_range(63));
      bit  we = 1'($urandom);
      bit  re = 1'($urandom);
      int  ra = ($urandom_range(3) == 0) ? wa / RATIO : int'($urandom_range(15));
      tick_a(we, wa, 8'($urandom), re, ra);
      checks += 3;
      if (bus_a.rd_valid_o !== e_valid) begin errors++; $display("FAIL rnd_valid %0d: got %b want %b", i, bus_a.rd_valid_o, e_valid); end
      if (bus_a.rd_data_o !== e_data) begin errors++; $display("FAIL rnd_data %0d: got %h want %h", i, bus_a.rd_data_o, e_data); end
      if (bus_a.collision_o !== e_coll) begin errors++; $display("FAIL rnd_coll %0d: got %b want %b", i, bus_a.collision_o, e_coll); end
    end
    for (int i = 0; i < RD_LAT; i++) tick_a(1'b0, 0, 8'h00, 1'b0, 0);
  endtask

  task automatic test_reset_midflight();
    int waited = 0;
    for (int i = 0; i < 4; i++) tick_a(1'b1, 20 + i, 8'($urandom | 8'h80), 1'b0, 0);
    tick_a(1'b0, 0, 8'h00, 1'b1, 5);
    enter_reset();
    for (int i = 0; i < 2; i++) begin
      tick_a(1'b0, 0, 8'h00, 1'b0, 0);
      checks++;
      if (bus_a.rd_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid %0d: got %b want 0", i, bus_a.rd_valid_o); end
    end
    leave_reset();
    while (done_a !== 1'b1 && waited < 40) begin
      tick_a(1'b0, 0, 8'h00, 1'b0, 0);
      waited++;
      checks++;
      if (bus_a.rd_valid_o !== 1'b0) begin errors++; $display("FAIL mid_sweep_valid %0d: got %b want 0", waited, bus_a.rd_valid_o); end
    end
    checks++;
    if (waited != DEPTH) begin errors++; $display("FAIL mid_done_time: got %0d want %0d", waited, DEPTH); end
    tick_a(1'b0, 0, 8'h00, 1'b1, 5);
    tick_a(1'b0, 0, 8'h00, 1'b0, 0);
    checks += 2;
    if (bus_a.rd_valid_o !== 1'b1) begin errors++; $display("FAIL mid_read_valid: got %b want 1", bus_a.rd_valid_o); end
    if (bus_a.rd_data_o !== 32'h0) begin errors++; $display("FAIL mid_read_data: got %h want 00000000", bus_a.rd_data_o); end
  endtask

  task automatic tick_b(input bit we, input int wa, input logic [7:0] wd, input bit re, input int ra);
    bus_b.wr_en_i = we; bus_b.wr_addr_i = 4'(wa); bus_b.wr_data_i = wd;
    bus_b.rd_en_i = re; bus_b.rd_addr_i = 4'(ra);
    @(posedge clk);
    #1;
  endtask

  task automatic test_ratio1();
    logic [7:0] m1 [16];
    logic [7:0] hold = 8'h00;
    logic [7:0] want;
    bus_a.wr_en_i = 1'b0; bus_a.rd_en_i = 1'b0;
    for (int i = 0; i < 16; i++) m1[i] = 8'h00;
    checks++;
    if (done_b !== 1'b1) begin errors++; $display("FAIL r1_done: got %b want 1", done_b); end
    tick_b(1'b1, 7, 8'h5A, 1'b0, 0);
    m1[7] = 8'h5A;
    tick_b(1'b0, 0, 8'h00, 1'b1, 7);
    hold = 8'h5A;
    checks += 2;
    if (bus_b.rd_valid_o !== 1'b1) begin errors++; $display("FAIL r1_valid: got %b want 1", bus_b.rd_valid_o); end
    if (bus_b.rd_data_o !== 8'h5A) begin errors++; $display("FAIL r1_data: got %h want 5a", bus_b.rd_data_o); end
    for (int i = 0; i < 80; i++) begin
      int         wa = int'($urandom_range(15));
      int         ra = ($urandom_range(2) == 0) ? wa : int'($urandom_range(15));
      bit         we = 1'($urandom);
      bit         re = 1'($urandom);
      logic [7:0] wd = 8'($urandom);
      tick_b(we, wa, wd, re, ra);
      if (re) hold = m1[ra];
      want = hold;
      checks += 3;
      if (bus_b.rd_valid_o !== re) begin errors++; $display("FAIL r1_rnd_valid %0d: got %b want %b", i, bus_b.rd_valid_o, re); end
      if (bus_b.rd_data_o !== want) begin errors++; $display("FAIL r1_rnd_data %0d: got %h want %h", i, bus_b.rd_data_o, want); end
      if (bus_b.collision_o !== (re && we && wa == ra)) begin
        errors++; $display("FAIL r1_rnd_coll %0d: got %b want %b", i, bus_b.collision_o, re && we && wa == ra);
      end
      if (we) m1[wa] = wd;
    end
  endtask

  initial begin
    bus_a.wr_en_i = 1'b0; bus_a.wr_addr_i = '0; bus_a.wr_data_i = '0;
    bus_a.rd_en_i = 1'b0; bus_a.rd_addr_i = '0;
    bus_b.wr_en_i = 1'b0; bus_b.wr_addr_i = '0; bus_b.wr_data_i = '0;
    bus_b.rd_en_i = 1'b0; bus_b.rd_addr_i = '0;
    #2;
    test_reset();
    test_init();
    test_lanes();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    test_ratio1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dpram_asym.md
DPRAM_ASYM -- requirements
Module: dpram_asym

Interface
REQ-001 The block SHALL have these parameters:
  - DLY, 1, simulation delay on all nonblocking assignments (no functional effect).
  - WR_W, 8, write-port data width in bits.
  - RATIO, 4, read width divided by write width; legal values 1, 2, 4, 8.
  - DEPTH, 16, number of read-width words; power of two, at least 2.
  - RD_LAT, 1, read latency in cycles; legal values 1, 2.
  - RD_W, WR_W*RATIO, read-port data width, derived.
  - RA_W, $clog2(DEPTH), read address width, derived.
  - WA_W, RA_W+$clog2(RATIO), write address width, derived.
REQ-002 The block SHALL have these ports:
  - clk_i  in  1  single clock; all logic is rising-edge.
  - rstn_i  in  1  reset; asynchronous and active-low.
  - init_done_o  out  1  high once the memory clear sweep is complete.
  - wr_en_i  in  1  write strobe.
  - wr_addr_i  in  WA_W  narrow-word write address.
  - wr_data_i  in  WR_W  write data.
  - rd_en_i  in  1  read strobe.
  - rd_addr_i  in  RA_W  wide-word read address.
  - rd_data_o  out  RD_W  read data.
  - rd_valid_o  out  1  rd_data_o is valid this cycle.
  - collision_o  out  1  the read being returned collided with a same-cycle write.

Function
REQ-003 The FSM SHALL have two states, INIT and READY; reset SHALL force INIT with sweep counter 0.
REQ-004 In INIT the block SHALL write all-zero to wide word [counter] each cycle and increment the counter.
REQ-005 INIT SHALL go to READY on the cycle after the counter writes word DEPTH-1; init_done_o SHALL be registered and rise exactly DEPTH cycles after rstn_i deasserts.
REQ-006 In INIT, wr_en_i and rd_en_i SHALL be ignored: no write, no rd_valid_o.
REQ-007 In READY, wr_en_i=1 SHALL write wr_data_i into lane wr_addr_i[$clog2(RATIO)-1:0] of wide word wr_addr_i[WA_W-1:$clog2(RATIO)]; the other lanes SHALL be unchanged.
REQ-008 Lane 0 SHALL occupy RD_W bits [WR_W-1:0] (little-endian packing).
REQ-009 For RATIO=1 the lane field SHALL be empty and the write SHALL cover the whole word.
REQ-010 In READY, rd_en_i=1 SHALL sample word rd_addr_i.
REQ-011 A read's data SHALL appear on rd_data_o with rd_valid_o=1 exactly RD_LAT cycles after the rd_en_i edge.
REQ-012 Back-to-back reads SHALL be accepted every cycle (full throughput).
REQ-013 When rd_valid_o=0, rd_data_o SHALL hold the last valid value.
REQ-014 A same-cycle read and write to the same wide word SHALL be read-first: the read returns pre-write contents and the write still completes.
REQ-015 collision_o SHALL pulse on the same cycle as that read's rd_valid_o; otherwise it SHALL be 0.
REQ-016 Out-of-range addresses cannot occur: all address bits are used and DEPTH is a power of two.
REQ-017 The read pipeline SHALL carry valid, data and collision together with no bubbles.

Reset
REQ-018 While rstn_i=0:
  - init_done_o, rd_valid_o and collision_o SHALL be 0.
  - rd_data_o SHALL be all-zero.
  - the FSM SHALL be in INIT and the counter at 0.
REQ-019 Reset asserted mid-operation SHALL:
  - discard in-flight reads, with no rd_valid_o pulse after release until a new read;
  - re-run the full clear sweep, so all words read 0 after init_done_o.
REQ-020 The memory array itself SHALL have no reset; it is cleared only by the sweep.

Verification
Scenarios use WR_W=8, RATIO=4, DEPTH=16, RD_LAT=2 unless stated.
REQ-021 Release reset, hold wr_en_i=1 -> init_done_o rises on cycle 16 after release; reading every word afterwards gives 0x00000000; writes during INIT have no effect.
REQ-022 Write 0x11,0x22,0x33,0x44 to wr_addr 0x14..0x17, then read rd_addr 5 -> 0x44332211 two cycles later with one rd_valid_o pulse.
REQ-023 Word 3 holds 0xAABBCCDD; in one cycle write 0xEE to wr_addr 0x0D and read rd_addr 3 -> returns 0xAABBCCDD with collision_o=1; the next read of word 3 returns 0xAABBEEDD with collision_o=0.
REQ-024 Read rd_addr 0..15 on 16 consecutive cycles -> 16 consecutive rd_valid_o cycles with data in order; rd_data_o then holds word 15's value.
REQ-025 Issue a read, then assert rstn_i=0 one cycle later -> no rd_valid_o pulse; after release the previously written word 5 reads 0 once init_done_o=1.
REQ-026 With RATIO=1 and RD_LAT=1, write 0x5A to address 7 and read address 7 -> 0x5A one cycle later.
